// File: rtl/sar_seq_ctrl_if.sv
// Bundle of the SAR sequencer's control, comparator and result-buffer signals.
// master: the sequencer itself; slave: the analog front end / back end around it.
interface sar_seq_ctrl_if #(
    parameter int unsigned ADC_BITS = 8,
    parameter int unsigned RES_W    = 4
);
    logic                start;
    logic [RES_W-1:0]    conv_bits;
    logic                cmp_clk;
    logic                cmp_done;
    logic                cmp_out;
    logic                sample;
    logic [ADC_BITS-1:0] dac_code;
    logic                busy;
    logic [ADC_BITS-1:0] data_out;
    logic                data_valid;
    logic                data_ready;
    logic                overflow;
    logic                timeout_err;
    logic                clr_flags;

    modport master (
        input  start, conv_bits, cmp_done, cmp_out, data_ready, clr_flags,
        output cmp_clk, sample, dac_code, busy, data_out, data_valid,
               overflow, timeout_err
    );

    modport slave (
        output start, conv_bits, cmp_done, cmp_out, data_ready, clr_flags,
        input  cmp_clk, sample, dac_code, busy, data_out, data_valid,
               overflow, timeout_err
    );
endinterface

// File: rtl/sar_seq_ctrl.sv
// Clocked SAR conversion sequencer: sample phase, MSB-first binary search via
// comparator request/done handshake, runtime resolution, one-entry result
// buffer with valid/ready and sticky overflow.
// Optional: define SAR_TIMEOUT_EN to force a '1' decision (and set
// timeout_err) after TIMEOUT_CYCLES WAIT cycles without cmp_done.
module sar_seq_ctrl #(
    parameter int unsigned ADC_BITS       = 8,
    parameter int unsigned SAMPLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned RES_W          = 4
) (
    input logic            clk,
    input logic            rst,
    sar_seq_ctrl_if.master bus
);
    localparam int unsigned IDX_W  = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
    localparam int unsigned SCNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    if (SAMPLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || (1 << RES_W) <= ADC_BITS) begin : g_bad_params
        $error("sar_seq_ctrl: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_COMPARE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADC_BITS-1:0] dac_q, dac_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    lsb_q, lsb_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [ADC_BITS-1:0] dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;

    logic [IDX_W-1:0]    lsb_req;
    logic [IDX_W-1:0]    idx_dec;
    logic                decide;
    logic                decide_bit;
    logic                forced;
    logic                offer;

`ifdef SAR_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] tcnt_q;
`endif

    // Lowest bit index to resolve; out-of-range resolutions fall back to full width.
    always_comb begin
        lsb_req = '0;
        if (bus.conv_bits != '0 && 32'(bus.conv_bits) <= ADC_BITS) begin
            lsb_req = IDX_W'(ADC_BITS - 32'(bus.conv_bits));
        end
    end

    assign idx_dec = idx_q - 1'b1;

    // Next-state, trial-code and bit-index update for the conversion FSM.
    always_comb begin
        state_d    = state_q;
        dac_d      = dac_q;
        idx_d      = idx_q;
        lsb_d      = lsb_q;
        scnt_d     = scnt_q;
        decide     = 1'b0;
        decide_bit = 1'b0;
        forced     = 1'b0;
        offer      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lsb_d   = lsb_req;
                    dac_d   = '0;
                    scnt_d  = SCNT_W'(SAMPLE_CYCLES - 1);
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (scnt_q == '0) begin
                    // The trial bit is set on the way into COMPARE so it is
                    // already on dac_code during the cmp_clk cycle.
                    idx_d             = IDX_W'(ADC_BITS - 1);
                    dac_d[ADC_BITS-1] = 1'b1;
                    state_d           = S_COMPARE;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            S_COMPARE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.cmp_done) begin
                    decide     = 1'b1;
                    decide_bit = bus.cmp_out;
                end
`ifdef SAR_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    decide     = 1'b1;
                    decide_bit = 1'b1;
                    forced     = 1'b1;
                end
`endif
                if (decide) begin
                    dac_d[idx_q] = decide_bit;
                    if (idx_q == lsb_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d          = idx_dec;
                        dac_d[idx_dec] = 1'b1;
                        state_d        = S_COMPARE;
                    end
                end
            end
            S_DONE: begin
                offer   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result buffer and sticky flags; a set event in the same cycle beats clr_flags.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;

        if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
        if (bus.clr_flags) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (offer) begin
            if (!valid_q || bus.data_ready) begin
                dout_d  = dac_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (forced) begin
            tmo_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dac_q   <= '0;
            idx_q   <= '0;
            lsb_q   <= '0;
            scnt_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dac_q   <= dac_d;
            idx_q   <= idx_d;
            lsb_q   <= lsb_d;
            scnt_q  <= scnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef SAR_TIMEOUT_EN
    // Per-bit WAIT cycle counter, cleared in COMPARE so it restarts on every WAIT entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_q <= '0;
        end else if (state_q == S_COMPARE) begin
            tcnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end
`endif

    assign bus.sample      = (state_q == S_SAMPLE);
    assign bus.cmp_clk     = (state_q == S_COMPARE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.dac_code    = dac_q;
    assign bus.data_out    = dout_q;
    assign bus.data_valid  = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: table of directed conversions plus
// hand-written handshake, overflow, stalled-comparator and reset sequences.
module tb_sar_seq_ctrl;
    localparam int unsigned ADC_BITS       = 8;
    localparam int unsigned SAMPLE_CYCLES  = 2;
    localparam int unsigned TIMEOUT_CYCLES = 15;
    localparam int unsigned RES_W          = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sar_seq_ctrl_if #(.ADC_BITS(ADC_BITS), .RES_W(RES_W)) bus ();

    sar_seq_ctrl #(
        .ADC_BITS(ADC_BITS),
        .SAMPLE_CYCLES(SAMPLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .RES_W(RES_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Comparator model settings (written by the main sequence)
    logic [7:0] target     = 8'h00;
    int         cmp_delay  = 1;
    int         skip_pulse = 0;

    // Comparator model state (owned by the comparator process)
    int         pulses = 0;
    int         pend   = 0;
    logic [7:0] trial  = 8'h00;

    // Analog comparator: keeps a bit when the trial code does not exceed the
    // input; answers cmp_delay cycles after each cmp_clk pulse.
    initial begin : comparator
        bus.cmp_done = 1'b0;
        bus.cmp_out  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.cmp_done = 1'b0;
            if (!rst) begin
                pend = 0;
            end else if (bus.cmp_clk) begin
                pulses = pulses + 1;
                trial  = bus.dac_code;
                pend   = (pulses == skip_pulse) ? 0 : cmp_delay;
            end else if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    bus.cmp_done = 1'b1;
                    bus.cmp_out  = (trial <= target);
                end
            end
            if (bus.sample) pulses = 0;
        end
    end

    typedef struct {
        logic [3:0] bits;
        logic [7:0] tgt;
        int         dly;
        logic [7:0] code;
        int         lat;
        int         npulse;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion; lat = edges from the start cycle until busy drops (-1 on timeout).
    task automatic convert(input logic [3:0] cb, input logic [7:0] tg, input int dly,
                           input int ready_at, output int lat);
        target        = tg;
        cmp_delay     = dly;
        lat           = -1;
        bus.conv_bits = cb;
        bus.start     = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 3) begin
                bus.start     = 1'b1;    // ignored while busy
                bus.conv_bits = 4'd1;
            end
            if (c == 4) bus.start = 1'b0;
            if (c == ready_at) bus.data_ready = 1'b1;
            if (!bus.busy) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;

        vecs[0] = '{4'd8,  8'hA5, 1, 8'hA5, 20, 8};
        vecs[1] = '{4'd4,  8'hA5, 1, 8'hA0, 12, 4};
        vecs[2] = '{4'd0,  8'hA5, 1, 8'hA5, 20, 8};
        vecs[3] = '{4'd12, 8'hA5, 1, 8'hA5, 20, 8};
        vecs[4] = '{4'd8,  8'h3C, 1, 8'h3C, 20, 8};
        vecs[5] = '{4'd1,  8'hA5, 1, 8'h80, 6,  1};
        vecs[6] = '{4'd8,  8'h00, 1, 8'h00, 20, 8};
        vecs[7] = '{4'd8,  8'hFF, 1, 8'hFF, 20, 8};
        vecs[8] = '{4'd8,  8'hA5, 5, 8'hA5, 52, 8};
        vecs[9] = '{4'd3,  8'h5A, 1, 8'h40, 10, 3};

        bus.start      = 1'b0;
        bus.conv_bits  = '0;
        bus.data_ready = 1'b0;
        bus.clr_flags  = 1'b0;
        rst            = 1'b0;
        repeat (3) tick();
        check("reset_ctrl", {26'd0, bus.sample, bus.cmp_clk, bus.busy, bus.data_valid,
                             bus.overflow, bus.timeout_err}, 32'd0);
        check("reset_dac", bus.dac_code, 32'd0);
        check("reset_dout", bus.data_out, 32'd0);
        rst = 1'b1;
        tick();

        // Directed conversion table with the consumer always ready
        bus.data_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            convert(vecs[v].bits, vecs[v].tgt, vecs[v].dly, -1, lat);
            check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("v%0d_valid", v), bus.data_valid, 1);
            check($sformatf("v%0d_data", v), bus.data_out, vecs[v].code);
            check($sformatf("v%0d_dac", v), bus.dac_code, vecs[v].code);
            check($sformatf("v%0d_pulses", v), pulses, vecs[v].npulse);
            check($sformatf("v%0d_ovf", v), bus.overflow, 0);
            tick();
            check($sformatf("v%0d_consumed", v), bus.data_valid, 0);
        end

        // Consumer stalled across two conversions: second result dropped
        bus.data_ready = 1'b0;
        convert(4'd8, 8'h3C, 1, -1, lat);
        check("stall1_data", bus.data_out, 32'h3C);
        convert(4'd8, 8'hC3, 1, -1, lat);
        check("stall2_data", bus.data_out, 32'h3C);
        check("stall2_valid", bus.data_valid, 1);
        check("stall2_ovf", bus.overflow, 1);
        check("stall2_dac", bus.dac_code, 32'hC3);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        check("clr_ovf", bus.overflow, 0);

        // Ready raised exactly in the DONE cycle: buffer frees and reloads together
        convert(4'd8, 8'hC3, 1, 19, lat);
        check("ready_done_lat", lat, 20);
        check("ready_done_data", bus.data_out, 32'hC3);
        check("ready_done_valid", bus.data_valid, 1);
        check("ready_done_ovf", bus.overflow, 0);
        tick();
        check("ready_done_consumed", bus.data_valid, 0);

        // Drop coinciding with clr_flags: the set wins
        bus.data_ready = 1'b0;
        convert(4'd8, 8'h3C, 1, -1, lat);
        bus.clr_flags = 1'b1;
        convert(4'd8, 8'h5A, 1, -1, lat);
        bus.clr_flags = 1'b0;
        check("set_wins_ovf", bus.overflow, 1);
        check("set_wins_data", bus.data_out, 32'h3C);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        bus.data_ready = 1'b1;
        tick();
        check("set_wins_cleared", {bus.overflow, bus.data_valid}, 0);

        // Comparator never answers on bit 5 (third pulse)
        skip_pulse = 3;
`ifdef SAR_TIMEOUT_EN
        convert(4'd8, 8'h85, 1, -1, lat);
        check("tmo_latency", lat, 34);
        check("tmo_data", bus.data_out, 32'hA0);
        check("tmo_err", bus.timeout_err, 1);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        check("tmo_clr", bus.timeout_err, 0);
`else
        target        = 8'h85;
        cmp_delay     = 1;
        bus.conv_bits = 4'd8;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (60) tick();
        check("stuck_busy", bus.busy, 1);
        check("stuck_valid", bus.data_valid, 0);
        check("stuck_tmo", bus.timeout_err, 0);
        check("stuck_dac", bus.dac_code, 32'hA0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("stuck_reset_busy", bus.busy, 0);
`endif
        skip_pulse = 0;
        tick();

        // Reset in the third WAIT cycle with a result sitting in the buffer
        bus.data_ready = 1'b0;
        convert(4'd8, 8'h3C, 1, -1, lat);
        check("pre_rst_valid", bus.data_valid, 1);
        target        = 8'hC3;
        bus.conv_bits = 4'd8;
        bus.start     = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
        end
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b0;
        tick();
        check("mid_rst_ctrl", {26'd0, bus.sample, bus.cmp_clk, bus.busy, bus.data_valid,
                               bus.overflow, bus.timeout_err}, 32'd0);
        check("mid_rst_dac", bus.dac_code, 32'd0);
        check("mid_rst_dout", bus.data_out, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", {bus.busy, bus.data_valid}, 0);
        convert(4'd8, 8'h5A, 1, -1, lat);
        check("post_rst_latency", lat, 20);
        check("post_rst_data", bus.data_out, 32'h5A);
        check("post_rst_valid", bus.data_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
